x_cal_sweep_ctrl: RTL and testbench

Sequences a calibration sweep of the variable delay line. For each tap it selects the tap, waits a settle period, then takes P_SAMPLES back-to-back snapshots of the delay-line thermometer word. It reduces each snapshot to an edge position and emits one {tap, min, max, no-edge} record per tap over a valid/ready handshake to the UART framer. It sits between the one-hot tap decoder, the delay-line capture flops and the UART sender, and replaces free-running tap increment with a deterministic, abortable sweep.

---
 rtl/x_cal_sweep_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_x_cal_sweep_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_cal_sweep_ctrl.sv
// x_cal_sweep_ctrl
//   Steps the variable delay line through taps 0..P_TAPS-1. For each tap it
//   selects the tap, waits for the line to settle, then takes P_SAMPLES
//   back-to-back snapshots of the thermometer word. Each snapshot is reduced
//   to an edge position, and one {tap, min, max, no-edge} record per tap is
//   handed to the UART framer over a valid/ready handshake. The sweep can be
//   aborted at any point.
//
// Ports
//   i_clk, i_nrst          clock, asynchronous active-low reset
//   i_start                start pulse, only honoured when idle
//   i_abort                abort the sweep, overrides everything else
//   i_data[P_WIDTH]        delay-line snapshot (synchronous to i_clk)
//   o_tap[TW]              selected tap, decoded to one-hot outside
//   o_capture              high in every cycle where i_data is sampled
//   o_busy                 high whenever the controller is not idle
//   o_res_valid/i_res_ready  result record handshake
//   o_res_tap/min/max/noedge  result record fields
//   o_done                 one-cycle pulse when the last record is accepted
//
// State     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for i_start
// S_SET     | tap selected, accumulators and timer reloaded (1 cycle)
// S_SETTLE  | delay line settling for P_SETTLE cycles
// S_SAMPLE  | P_SAMPLES consecutive snapshots, o_capture high
// S_EMIT    | record presented, waiting for i_res_ready
// S_DONE    | sweep complete, o_done pulse (1 cycle)

module x_cal_sweep_ctrl #(
  parameter int P_WIDTH   = 256,
  parameter int P_TAPS    = 256,
  parameter int P_SETTLE  = 16,
  parameter int P_SAMPLES = 8,
  localparam int TW = (P_TAPS > 1) ? $clog2(P_TAPS) : 1,
  localparam int EW = $clog2(P_WIDTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [P_WIDTH-1:0] i_data,
  output logic [TW-1:0]      o_tap,
  output logic               o_capture,
  output logic               o_busy,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [TW-1:0]      o_res_tap,
  output logic [EW-1:0]      o_res_min,
  output logic [EW-1:0]      o_res_max,
  output logic               o_res_noedge,
  output logic               o_done
);

  localparam int CNT_MAX = (P_SETTLE > P_SAMPLES) ? P_SETTLE : P_SAMPLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SET    = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tap_q, tap_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   min_q, min_d;
  logic [EW-1:0]   max_q, max_d;
  logic            noedge_q, noedge_d;
  logic            busy_q, busy_d;
  logic            capture_q, capture_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  logic [EW-1:0]   edge_pos;
  logic            no_edge;

  // Lowest index above bit 0 that differs from bit 0. Scanning downwards lets
  // the last hit win, which is the lowest one; no hit leaves P_WIDTH.
  always_comb begin
    edge_pos = EW'(P_WIDTH);
    for (int i = P_WIDTH - 1; i >= 1; i--) begin
      if (i_data[i] != i_data[0]) edge_pos = EW'(i);
    end
    no_edge = (edge_pos == EW'(P_WIDTH));
  end

  // The settle and sample timers share one down-counter: SET loads the settle
  // length, the end of SETTLE reloads it with the sample count.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    cnt_d    = cnt_q;
    min_d    = min_q;
    max_d    = max_q;
    noedge_d = noedge_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_SET;
          tap_d   = '0;
        end
      end
      S_SET: begin
        min_d    = EW'(P_WIDTH);
        max_d    = '0;
        noedge_d = 1'b0;
        cnt_d    = CW'(P_SETTLE - 1);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(P_SAMPLES - 1);
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SAMPLE: begin
        if (edge_pos < min_q) min_d = edge_pos;
        if (edge_pos > max_q) max_d = edge_pos;
        noedge_d = noedge_q | no_edge;
        if (cnt_q == '0) begin
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_EMIT: begin
        if (i_res_ready) begin
          if (tap_q == TW'(P_TAPS - 1)) begin
            state_d = S_DONE;
          end else begin
            tap_d   = tap_q + TW'(1);
            state_d = S_SET;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any same-cycle handshake, so that record is dropped.
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tap_d   = '0;
    end

    // Status outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    busy_d    = (state_d != S_IDLE);
    capture_d = (state_d == S_SAMPLE);
    valid_d   = (state_d == S_EMIT);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= S_IDLE;
      tap_q     <= '0;
      cnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      noedge_q  <= 1'b0;
      busy_q    <= 1'b0;
      capture_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      noedge_q  <= noedge_d;
      busy_q    <= busy_d;
      capture_q <= capture_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign o_tap        = tap_q;
  assign o_capture    = capture_q;
  assign o_busy       = busy_q;
  assign o_res_valid  = valid_q;
  assign o_res_tap    = tap_q;
  assign o_res_min    = min_q;
  assign o_res_max    = max_q;
  assign o_res_noedge = noedge_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_x_cal_sweep_ctrl.sv
// Bench for x_cal_sweep_ctrl. The main instance (4 taps, settle 2, 2 samples)
// is checked every cycle against a timeline model: within a tap, cycle offset
// 0 is the tap select, 1..NS settle, NS+1..NS+NP capture, later cycles emit.
// A second instance (3 samples) checks per-sample min/max reduction.

module tb_x_cal_sweep_ctrl;

  localparam int W  = 256;
  localparam int NT = 4;
  localparam int NS = 2;
  localparam int NP = 2;
  localparam int TW = 2;
  localparam int EW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b1;
  logic [W-1:0]  data = '0;

  logic [TW-1:0] o_tap, o_res_tap;
  logic          o_capture, o_busy, o_res_valid, o_res_noedge, o_done;
  logic [EW-1:0] o_res_min, o_res_max;

  logic          start3 = 1'b0;
  logic [W-1:0]  data3 = '0;
  logic [0:0]    o_tap3, o_res_tap3;
  logic          o_capture3, o_busy3, o_res_valid3, o_res_noedge3, o_done3;
  logic [EW-1:0] o_res_min3, o_res_max3;

  always #5 clk = ~clk;

  x_cal_sweep_ctrl #(.P_WIDTH(W), .P_TAPS(NT), .P_SETTLE(NS), .P_SAMPLES(NP)) u_dut (
    .i_clk(clk), .i_nrst(rst_n), .i_start(start), .i_abort(abort), .i_data(data),
    .o_tap(o_tap), .o_capture(o_capture), .o_busy(o_busy),
    .o_res_valid(o_res_valid), .i_res_ready(ready), .o_res_tap(o_res_tap),
    .o_res_min(o_res_min), .o_res_max(o_res_max), .o_res_noedge(o_res_noedge),
    .o_done(o_done)
  );

  x_cal_sweep_ctrl #(.P_WIDTH(W), .P_TAPS(2), .P_SETTLE(2), .P_SAMPLES(3)) u_dut3 (
    .i_clk(clk), .i_nrst(rst_n), .i_start(start3), .i_abort(1'b0), .i_data(data3),
    .o_tap(o_tap3), .o_capture(o_capture3), .o_busy(o_busy3),
    .o_res_valid(o_res_valid3), .i_res_ready(1'b1), .o_res_tap(o_res_tap3),
    .o_res_min(o_res_min3), .o_res_max(o_res_max3), .o_res_noedge(o_res_noedge3),
    .o_done(o_done3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_active, m_done, m_noedge;
  int m_tap, m_off, m_min, m_max;

  function automatic int edge_of(input logic [W-1:0] d);
    int e = 1;
    while (e < W && d[e] == d[0]) e++;
    return e;
  endfunction

  function automatic bit exp_cap();
    return m_active && (m_off >= NS + 1) && (m_off <= NS + NP);
  endfunction

  function automatic bit exp_val();
    return m_active && (m_off > NS + NP);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int e;
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_tap = 0; m_off = 0;
      m_min = 0; m_max = 0; m_noedge = 0;
    end else if (abort && (m_active || m_done)) begin
      m_active = 0; m_done = 0; m_tap = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_tap = 0; m_off = 0;
        m_min = W; m_max = 0; m_noedge = 0;
      end
    end else begin
      if (exp_cap()) begin
        e = edge_of(data);
        if (e < m_min) m_min = e;
        if (e > m_max) m_max = e;
        if (e == W) m_noedge = 1;
      end
      if (exp_val() && ready) begin
        if (m_tap == NT - 1) begin
          m_active = 0; m_done = 1;
        end else begin
          m_tap++; m_off = 0;
          m_min = W; m_max = 0; m_noedge = 0;
        end
      end else begin
        m_off++;
      end
    end
  end

  // ---------------- per-cycle compare + record log ----------------
  typedef struct {int tap; int mn; int mx; bit ne;} rec_t;
  rec_t rec_q[$];
  rec_t rec3_q[$];
  int busy_cycles = 0;
  int done_cnt    = 0;

  always @(negedge clk) begin
    rec_t r;
    if (rst_n) begin
      chk("busy", o_busy, m_active || m_done);
      chk("tap", o_tap, m_tap);
      chk("capture", o_capture, exp_cap());
      chk("valid", o_res_valid, exp_val());
      chk("done", o_done, m_done);
      if (exp_val()) begin
        chk("res_tap", o_res_tap, m_tap);
        chk("res_min", o_res_min, m_min);
        chk("res_max", o_res_max, m_max);
        chk("res_noedge", o_res_noedge, m_noedge);
      end
      if (o_busy) busy_cycles++;
      if (o_done) done_cnt++;
      if (o_res_valid && ready && !abort) begin
        r.tap = int'(o_res_tap); r.mn = int'(o_res_min);
        r.mx = int'(o_res_max);  r.ne = o_res_noedge;
        rec_q.push_back(r);
      end
      if (o_res_valid3) begin
        r.tap = int'(o_res_tap3); r.mn = int'(o_res_min3);
        r.mx = int'(o_res_max3);  r.ne = o_res_noedge3;
        rec3_q.push_back(r);
      end
    end
  end

  // Second instance: successive captures see 0x0F, 0x3F, 0x07.
  logic [W-1:0] tbl3 [3];
  int k3 = 0;
  always @(posedge clk) begin
    #1;
    if (o_capture3) begin
      data3 = tbl3[k3];
      k3 = (k3 + 1) % 3;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 80; k++) begin
      if (o_done) break;
      step();
    end
    chk(name, o_done, 1'b1);
    step();
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 40; k++) begin
      if (o_res_valid) break;
      step();
    end
    chk(name, o_res_valid, 1'b1);
  endtask

  logic [W-1:0] pat [3];
  int           pat_e [3];
  bit           pat_ne [3];

  initial begin
    tbl3[0] = 256'h0F; tbl3[1] = 256'h3F; tbl3[2] = 256'h07;
    pat[0] = '1;                      pat_e[0] = 256; pat_ne[0] = 1;
    pat[1] = ~(256'h1F);              pat_e[1] = 5;   pat_ne[1] = 0;
    pat[2] = 256'h1;                  pat_e[2] = 1;   pat_ne[2] = 0;

    // Reset values
    repeat (3) step();
    chk("rst_busy", o_busy, 0);
    chk("rst_tap", o_tap, 0);
    chk("rst_capture", o_capture, 0);
    chk("rst_valid", o_res_valid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_res_tap", o_res_tap, 0);
    chk("rst_res_min", o_res_min, 0);
    chk("rst_res_max", o_res_max, 0);
    chk("rst_res_noedge", o_res_noedge, 0);
    rst_n = 1'b1;
    step();

    // Abort while idle does nothing
    abort = 1'b1; step(); abort = 1'b0; step();
    chk("idle_abort_busy", o_busy, 0);

    // Full sweep with 0xFF, plus a start pulse mid-sweep that must be ignored
    data = 256'hFF; ready = 1'b1;
    rec_q.delete(); busy_cycles = 0; done_cnt = 0;
    pulse_start();
    repeat (8) step();
    pulse_start();
    wait_done("sweep_ff_done");
    chk("sweep_ff_nrec", rec_q.size(), 4);
    for (int i = 0; i < rec_q.size() && i < 4; i++) begin
      chk("sweep_ff_tap", rec_q[i].tap, i);
      chk("sweep_ff_min", rec_q[i].mn, 8);
      chk("sweep_ff_max", rec_q[i].mx, 8);
      chk("sweep_ff_ne", rec_q[i].ne, 0);
    end
    chk("sweep_ff_done_cnt", done_cnt, 1);
    // 4 taps x (1 + 2 + 2 + 1) cycles plus the done cycle
    chk("sweep_ff_busy_cycles", busy_cycles, 25);
    chk("sweep_ff_tap_hold", o_tap, 3);

    // Edge function patterns
    for (int p = 0; p < 3; p++) begin
      data = pat[p];
      rec_q.delete();
      pulse_start();
      wait_done("edge_done");
      chk("edge_nrec", rec_q.size(), 4);
      if (rec_q.size() > 0) begin
        chk("edge_min", rec_q[0].mn, pat_e[p]);
        chk("edge_max", rec_q[0].mx, pat_e[p]);
        chk("edge_ne", rec_q[0].ne, pat_ne[p]);
      end
    end

    // Backpressure: ready low for 10 cycles in EMIT
    data = 256'hFF; ready = 1'b0;
    pulse_start();
    wait_valid("bp_valid_reached");
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_valid_held", o_res_valid, 1);
      chk("bp_tap_held", o_tap, 0);
      chk("bp_min_held", o_res_min, 8);
    end
    ready = 1'b1;
    step();
    chk("bp_next_tap", o_tap, 1);
    chk("bp_valid_drop", o_res_valid, 0);
    chk("bp_busy", o_busy, 1);
    wait_done("bp_done");

    // Abort during SETTLE of tap 2
    done_cnt = 0;
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      if (o_tap == 2) break;
      step();
    end
    chk("ab_reach_tap2", o_tap, 2);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", o_busy, 0);
    chk("ab_tap", o_tap, 0);
    chk("ab_valid", o_res_valid, 0);
    repeat (5) step();
    chk("ab_no_done", done_cnt, 0);
    rec_q.delete();
    pulse_start();
    wait_done("ab_restart_done");
    chk("ab_restart_nrec", rec_q.size(), 4);
    if (rec_q.size() > 0) chk("ab_restart_tap0", rec_q[0].tap, 0);
    chk("ab_restart_done_cnt", done_cnt, 1);

    // Per-sample variation on the 3-sample instance
    rec3_q.delete();
    start3 = 1'b1; step(); start3 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_done3) break;
      step();
    end
    chk("v3_done", o_done3, 1);
    chk("v3_nrec", rec3_q.size(), 2);
    for (int i = 0; i < rec3_q.size() && i < 2; i++) begin
      chk("v3_tap", rec3_q[i].tap, i);
      chk("v3_min", rec3_q[i].mn, 3);
      chk("v3_max", rec3_q[i].mx, 6);
      chk("v3_ne", rec3_q[i].ne, 0);
    end

    // Asynchronous reset while in EMIT
    ready = 1'b0;
    pulse_start();
    wait_valid("rst_emit_reached");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", o_res_valid, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_tap", o_tap, 0);
    chk("arst_min", o_res_min, 0);
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (3) step();
    chk("arst_idle", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
